// File: rtl/mem_request_responder.sv
// mem_request_responder
//   Memory-side responder for the load/store queue request interface.
//   Tagged read/write requests are queued in an in-order FIFO, serviced one
//   at a time against a word-addressed data array after a fixed latency, and
//   answered with one tagged response each.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   addr_in    request byte address (bits [1:0] ignored)
//   data_in    store data (ignored for reads)
//   rw_in      1 = write, 0 = read
//   id_in      ld/st queue id of the request
//   valid_in   request present this cycle
//   data_out   read data, or the written data for writes
//   id_out     id of the request being answered
//   ready_out  single-cycle response-valid pulse
//   stall_out  request FIFO full; requester must hold off
module mem_request_responder #(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        rw_in,
    input  logic [3:0]  id_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic [3:0]  id_out,
    output logic        ready_out,
    output logic        stall_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(LATENCY) + 1;
    localparam int IW = $clog2(MEM_WORDS);

    localparam logic [LW-1:0] CNT_LOAD = LW'(LATENCY - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Request FIFO storage
    logic [IW-1:0] q_idx  [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic          q_rw   [DEPTH];
    logic [3:0]    q_id   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    // Service stage
    state_t        state;
    logic [LW-1:0] cnt;
    logic [IW-1:0] s_idx;
    logic [31:0]   s_data;
    logic          s_rw;
    logic [3:0]    s_id;

    logic [31:0]   mem [MEM_WORDS];

    logic          push;
    logic          pop;
    logic          access;
    logic [IW-1:0] req_idx;
    logic          unused_addr_bits;

    // Upper address bits alias onto the array; byte-offset bits are dropped.
    assign req_idx          = addr_in[IW+1:2];
    assign unused_addr_bits = ^{addr_in[31:IW+2], addr_in[1:0]};

    // Full flag depends only on registered count, never on valid_in.
    assign stall_out = (count == FULL);
    assign push      = valid_in && !stall_out;
    assign access    = (state == BUSY) && (cnt == '0);
    // The head is taken either from idle or on the very edge that finishes
    // the current access, which gives one response per LATENCY cycles.
    assign pop       = (count != '0) && ((state == IDLE) || access);

    // Datapath storage: FIFO entries, service register and array carry no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[tail]  <= req_idx;
            q_data[tail] <= data_in;
            q_rw[tail]   <= rw_in;
            q_id[tail]   <= id_in;
        end
        if (pop) begin
            s_idx  <= q_idx[head];
            s_data <= q_data[head];
            s_rw   <= q_rw[head];
            s_id   <= q_id[head];
        end
        if (access && s_rw) begin
            mem[s_idx] <= s_data;
        end
    end

    // Control: pointers, occupancy, service FSM and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            state     <= IDLE;
            cnt       <= '0;
            ready_out <= 1'b0;
            data_out  <= '0;
            id_out    <= '0;
        end else begin
            ready_out <= access;
            if (access) begin
                id_out   <= s_id;
                // Array read sees the value from before any write on this edge.
                data_out <= s_rw ? s_data : mem[s_idx];
            end

            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (!access) begin
                        cnt <= cnt - LW'(1);
                    end else if (pop) begin
                        cnt <= CNT_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_responder.sv
// Directed testbench for mem_request_responder (DEPTH=4, LATENCY=2,
// MEM_WORDS=1024). Responses are collected by a monitor into queues and
// compared in order against hand-computed values.
module tb_mem_request_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic        rw_in;
    logic [3:0]  id_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic [3:0]  id_out;
    logic        ready_out;
    logic        stall_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0]  r_id   [$];
    logic [31:0] r_data [$];
    int          r_cyc  [$];

    mem_request_responder #(
        .DEPTH    (4),
        .LATENCY  (2),
        .MEM_WORDS(1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .rw_in    (rw_in),
        .id_in    (id_in),
        .valid_in (valid_in),
        .data_out (data_out),
        .id_out   (id_out),
        .ready_out(ready_out),
        .stall_out(stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (ready_out === 1'b1) begin
            r_id.push_back(id_out);
            r_data.push_back(data_out);
            r_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request; waits (bounded) for stall_out=0 so it is accepted
    // on the next rising edge. Returns #1 after that edge with valid_in low.
    task automatic send(input logic rw, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] id);
        int t;
        t = 0;
        while (stall_out === 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (stall_out !== 1'b0) begin
            chk("send_stall_timeout", {31'd0, stall_out}, 32'd0);
        end
        rw_in    = rw;
        addr_in  = addr;
        data_in  = data;
        id_in    = id;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [3:0] eid,
                               input logic [31:0] edata, output int ecyc);
        int t;
        t    = 0;
        ecyc = -1;
        while (r_id.size() == 0 && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (r_id.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_id"}, {28'd0, r_id.pop_front()}, {28'd0, eid});
            chk({tag, "_data"}, r_data.pop_front(), edata);
            ecyc = r_cyc.pop_front();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic        t4_rw   [12];
    logic [31:0] t4_addr [12];
    logic [31:0] t4_data [12];
    logic [31:0] t4_exp  [12];

    initial begin
        int c0;
        int c1;
        int n;

        rst      = 1'b1;
        addr_in  = '0;
        data_in  = '0;
        rw_in    = 1'b0;
        id_in    = '0;
        valid_in = 1'b0;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_ready", {31'd0, ready_out}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_id",    {28'd0, id_out},    32'd0);
        chk("rst_data",  data_out,           32'd0);

        // Write then read, with exact latency
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'd3);            // E0
        chk("lat_e0", {31'd0, ready_out}, 32'd0);
        @(posedge clk); #1;                                  // E1
        chk("lat_e1", {31'd0, ready_out}, 32'd0);
        @(posedge clk); #1;                                  // E2
        chk("lat_e2", {31'd0, ready_out}, 32'd0);
        @(posedge clk); #1;                                  // E3
        chk("lat_e3_ready", {31'd0, ready_out}, 32'd1);
        chk("lat_e3_id",    {28'd0, id_out},    32'd3);
        chk("lat_e3_data",  data_out,           32'hDEADBEEF);
        @(posedge clk); #1;
        chk("pulse_end", {31'd0, ready_out}, 32'd0);
        chk("hold_id",   {28'd0, id_out},    32'd3);
        expect_resp("wr1", 4'd3, 32'hDEADBEEF, c0);
        send(1'b0, 32'h10, 32'h0, 4'd4);
        data_in = 32'h12345678;
        expect_resp("rd1", 4'd4, 32'hDEADBEEF, c0);

        // Five back-to-back requests, responses in order, 2 cycles apart
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 32'h20 + 32'(4 * i), 32'h100 + 32'(i), 4'(i));
        end
        expect_resp("b2b0", 4'd0, 32'h100, c0);
        for (int i = 1; i < 5; i++) begin
            expect_resp($sformatf("b2b%0d", i), 4'(i), 32'h100 + 32'(i), c1);
            chk($sformatf("b2b_gap%0d", i), 32'(c1 - c0), 32'd2);
            c0 = c1;
        end

        // Fill the FIFO, then try to sneak id 9 in while stalled
        n = 0;
        do begin
            send(1'b1, 32'h40 + 32'(4 * n), 32'h300 + 32'(n), 4'(n));
            n++;
        end while (stall_out !== 1'b1 && n < 10);
        chk("full_stall", {31'd0, stall_out}, 32'd1);
        rw_in    = 1'b0;
        addr_in  = 32'h10;
        id_in    = 4'd9;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            expect_resp($sformatf("fill%0d", i), 4'(i), 32'h300 + 32'(i), c0);
        end
        idle_cycles(10);
        chk("no_id9", 32'(r_id.size()), 32'd0);

        // Interleaved writes/reads to 0x0,0x4,0x8 (pointers wrap)
        for (int i = 0; i < 12; i++) begin
            t4_rw[i]   = (i % 2 == 0);
            t4_addr[i] = 32'(4 * ((i / 2) % 3));
            t4_data[i] = 32'hC000 + 32'(i);
        end
        t4_exp[0]  = 32'hC000; t4_exp[1]  = 32'hC000;
        t4_exp[2]  = 32'hC002; t4_exp[3]  = 32'hC002;
        t4_exp[4]  = 32'hC004; t4_exp[5]  = 32'hC004;
        t4_exp[6]  = 32'hC006; t4_exp[7]  = 32'hC006;
        t4_exp[8]  = 32'hC008; t4_exp[9]  = 32'hC008;
        t4_exp[10] = 32'hC00A; t4_exp[11] = 32'hC00A;
        for (int i = 0; i < 12; i++) begin
            send(t4_rw[i], t4_addr[i], t4_rw[i] ? t4_data[i] : 32'hFFFF_FFFF, 4'(i));
        end
        for (int i = 0; i < 12; i++) begin
            expect_resp($sformatf("rw%0d", i), 4'(i), t4_exp[i], c0);
        end

        // Async reset with 3 requests pending
        send(1'b1, 32'h80, 32'h11110000, 4'd1);              // E0
        send(1'b1, 32'h10, 32'hBAD00001, 4'd2);              // E1
        send(1'b1, 32'h10, 32'hBAD00002, 4'd3);              // E2
        send(1'b1, 32'h10, 32'hBAD00003, 4'd4);              // E3
        chk("pre_rst_ready", {31'd0, ready_out}, 32'd1);
        chk("pre_rst_id",    {28'd0, id_out},    32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_ready", {31'd0, ready_out}, 32'd0);
        chk("arst_stall", {31'd0, stall_out}, 32'd0);
        chk("arst_id",    {28'd0, id_out},    32'd0);
        chk("arst_data",  data_out,           32'd0);
        expect_resp("pre_rst_resp", 4'd1, 32'h11110000, c0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        idle_cycles(10);
        chk("arst_no_resp", 32'(r_id.size()), 32'd0);
        send(1'b0, 32'h10, 32'h0, 4'd5);
        expect_resp("arst_rd10", 4'd5, 32'hDEADBEEF, c0);
        send(1'b0, 32'h80, 32'h0, 4'd6);
        expect_resp("arst_rd80", 4'd6, 32'h11110000, c0);

        // Address aliasing
        send(1'b1, 32'h1000, 32'hA5A5A5A5, 4'd7);
        send(1'b0, 32'h0, 32'h0, 4'd8);
        expect_resp("alias_wr", 4'd7, 32'hA5A5A5A5, c0);
        expect_resp("alias_rd", 4'd8, 32'hA5A5A5A5, c0);

        idle_cycles(5);
        chk("final_empty", 32'(r_id.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_request_responder.md
Name: mem_request_responder

Overview:
- Memory-side responder for the load/store queue request interface.
- Accepts tagged read/write requests (addr, data, rw, 4-bit ld/st id) into a small in-order request FIFO.
- Services each request against an internal word-addressed data array after a fixed access latency.
- Returns one tagged response per completed request. Raises stall_out when it cannot accept more requests.

Parameters:
- DEPTH, 4, request FIFO entries (power of two, 2..16).
- LATENCY, 2, cycles a request occupies the service stage before its response issues (>=1).
- MEM_WORDS, 1024, 32-bit words in the data array (power of two). Index is addr_in[log2(MEM_WORDS)+1:2].

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- addr_in  input  32  request byte address (word aligned; bits [1:0] ignored)
- data_in  input  32  store data (ignored for reads)
- rw_in  input  1  1 = write, 0 = read
- id_in  input  4  ld/st queue id of the request
- valid_in  input  1  request present on addr/data/rw/id this cycle
- data_out  output  32  read data, or the written data for writes
- id_out  output  4  ld/st id of the request being answered
- ready_out  output  1  response valid this cycle (single-cycle pulse)
- stall_out  output  1  request FIFO full; requester must hold off

Behaviour:
- Reset (async, active-high):
  - FIFO head/tail/count = 0; service FSM = IDLE.
  - data_out = 0, id_out = 0, ready_out = 0.
  - stall_out = 0, since it is derived from count.
  - Data array contents are not reset.
  - Reset mid-operation discards all queued and in-service requests; no response ever issues for them.
- Acceptance:
  - A request is enqueued at a rising edge iff valid_in=1 and stall_out=0.
  - valid_in while stall_out=1 is ignored: no enqueue, no error, nothing lost from the queue.
- stall_out = (count == DEPTH). It is combinational from registered count, so it is a function of state only and never of valid_in.
- Service FSM, states IDLE and BUSY, with down-counter cnt of width ceil(log2(LATENCY))+1:
  - IDLE, count>0 at an edge: pop head into service register; cnt = LATENCY-1; go to BUSY.
  - BUSY, cnt>0: cnt decrements.
  - BUSY, cnt==0, access edge: perform the access and register the response (ready_out=1, id_out=service id).
    - Write: mem[index] = data_in; data_out = data_in.
    - Read: data_out = mem[index], reading the array value before any write performed on this edge.
  - On the same access edge, if count>0, pop the next head with cnt = LATENCY-1 and stay BUSY; otherwise go to IDLE.
  - ready_out is 1 for exactly the cycle after an access edge, else 0. data_out/id_out hold their last values when ready_out=0.
- Latency: with an idle FIFO, a request accepted at edge E0 gives ready_out=1 in the cycle after edge E0+LATENCY+1.
- Throughput: one response per LATENCY cycles when the FIFO stays non-empty.
- Ordering: strictly in order of acceptance. A read after a write to the same word always returns the new data.
- Simultaneous enqueue and pop at the same edge: count is unchanged, both the head and tail pointers advance.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Address aliasing: bits above the index are ignored (0x0000_1000 aliases 0x0000_0000 for MEM_WORDS=1024).
- id values are opaque: echoed, never checked for uniqueness.

Test Plan:
- Reset, then write addr 0x10 data 0xDEADBEEF id 3 at E0 -> ready_out=1, id_out=3, data_out=0xDEADBEEF in the cycle after E3 (LATENCY=2). Then read 0x10 id 4 -> data_out=0xDEADBEEF, id_out=4.
- Present 5 back-to-back valid requests (ids 0..4) with no idle gap -> stall_out=1 after the 4th is accepted is not required. The requirement is that the 5th is accepted only in a cycle where stall_out=0. Responses ids 0..4 appear in order, spaced 2 cycles apart.
- Hold stall_out=1 by filling the FIFO, then drive valid_in=1 with id 9 during the stall -> id 9 never appears on id_out. Queue contents are unaffected.
- 12 interleaved writes/reads to addrs 0x0,0x4,0x8 -> FIFO pointers wrap at least twice. Every read returns the most recent prior write to its word.
- Assert rst asynchronously while 3 requests are pending -> ready_out=0, stall_out=0 immediately, and no response follows. A new read of a previously written address then returns the preserved array value.
- Write 0xA5A5A5A5 to 0x1000, then read 0x0 -> data_out=0xA5A5A5A5 (aliasing).
